// File: rtl/z80fi_insn_collector_pkg.sv
// Shared widths, FSM states and packet structures for the z80fi instruction collector.
// Also holds the byte-lane insert helper used when assembling the opcode word.
package z80fi_insn_collector_pkg;

   localparam int INSN_W  = 32;
   localparam int LEN_W   = 3;
   localparam int PC_W    = 16;
   localparam int RNUM_W  = 4;
   localparam int RDATA_W = 16;
   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 8;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_e;

   typedef struct packed {
      logic [INSN_W-1:0]  insn;
      logic [LEN_W-1:0]   len;
      logic [PC_W-1:0]    pc;
      logic               reg1_rd;
      logic [RNUM_W-1:0]  reg1_rnum;
      logic [RDATA_W-1:0] reg1_rdata;
      logic               reg2_rd;
      logic [RNUM_W-1:0]  reg2_rnum;
      logic [RDATA_W-1:0] reg2_rdata;
   } core_t;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] waddr;
      logic [DATA_W-1:0] wdata;
      logic              wr2;
      logic [ADDR_W-1:0] waddr2;
      logic [DATA_W-1:0] wdata2;
   } mem_t;

   function automatic logic [INSN_W-1:0] insert_byte(
      input logic [INSN_W-1:0] insn,
      input logic [LEN_W-1:0]  idx,
      input logic [7:0]        b
   );
      logic [INSN_W-1:0] r;
      r = insn;
      case (idx)
         3'd0:    r[7:0]   = b;
         3'd1:    r[15:8]  = b;
         3'd2:    r[23:16] = b;
         3'd3:    r[31:24] = b;
         default: r        = insn;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/z80fi_insn_collector_mem_wr_slots.sv
// Two-entry memory-write capture for one instruction; a third write raises ovf and is dropped.
// merged exposes the slots including this cycle's write so the retire snapshot can see it.
module z80fi_insn_collector_mem_wr_slots
   import z80fi_insn_collector_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              wr,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   output mem_t              merged,
   output logic              ovf
);

   mem_t slots_r;

   // Fold the current write into the first free slot.
   always_comb begin
      merged = slots_r;
      ovf    = 1'b0;
      if (wr) begin
         if (!slots_r.wr) begin
            merged.wr    = 1'b1;
            merged.waddr = waddr;
            merged.wdata = wdata;
         end else if (!slots_r.wr2) begin
            merged.wr2    = 1'b1;
            merged.waddr2 = waddr;
            merged.wdata2 = wdata;
         end else begin
            ovf = 1'b1;
         end
      end else begin
         ovf = 1'b0;
      end
   end

   // Slot storage, emptied when the owning instruction retires.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slots_r <= '0;
      end else if (clr) begin
         slots_r <= '0;
      end else begin
         slots_r <= merged;
      end
   end

endmodule

// File: rtl/z80fi_insn_collector.sv
// Assembles per-cycle core retirement events into one registered z80fi packet per instruction,
// strobing z80fi_valid for the cycle after ev_done; overflow/protocol faults set sticky z80fi_err.
module z80fi_insn_collector
   import z80fi_insn_collector_pkg::*;
#(
   parameter int MAX_LEN   = 4,
   parameter bit CHECK_OVF = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ev_fetch,
   input  logic [7:0]          ev_fetch_byte,
   input  logic [PC_W-1:0]     ev_fetch_pc,
   input  logic [1:0]          ev_reg_rd,
   input  logic [7:0]          ev_reg_rnum,
   input  logic [31:0]         ev_reg_rdata,
   input  logic                ev_mem_wr,
   input  logic [ADDR_W-1:0]   ev_mem_waddr,
   input  logic [DATA_W-1:0]   ev_mem_wdata,
   input  logic                ev_done,
   output logic                z80fi_valid,
   output logic [INSN_W-1:0]   z80fi_insn,
   output logic [LEN_W-1:0]    z80fi_insn_len,
   output logic [PC_W-1:0]     z80fi_pc_rdata,
   output logic [RNUM_W-1:0]   z80fi_reg1_rnum,
   output logic [RNUM_W-1:0]   z80fi_reg2_rnum,
   output logic [RDATA_W-1:0]  z80fi_reg1_rdata,
   output logic [RDATA_W-1:0]  z80fi_reg2_rdata,
   output logic                z80fi_reg1_rd,
   output logic                z80fi_reg2_rd,
   output logic                z80fi_mem_wr,
   output logic                z80fi_mem_wr2,
   output logic [ADDR_W-1:0]   z80fi_mem_waddr,
   output logic [ADDR_W-1:0]   z80fi_mem_waddr2,
   output logic [DATA_W-1:0]   z80fi_mem_wdata,
   output logic [DATA_W-1:0]   z80fi_mem_wdata2,
   output logic                z80fi_err
);

   localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

   state_e state_r, state_nxt_s;
   core_t  acc_r, acc_nxt_s;
   core_t  pkt_r;
   mem_t   mem_pkt_r, mem_merged_s;
   logic   mem_ovf_s;
   logic   byte_ovf_s;
   logic   done_ok_s;
   logic   proto_err_s;
   logic   valid_r;
   logic   err_r;

   z80fi_insn_collector_mem_wr_slots u_mem_wr_slots (
      .clk    (clk),
      .rst    (reset),
      .clr    (done_ok_s),
      .wr     (ev_mem_wr),
      .waddr  (ev_mem_waddr),
      .wdata  (ev_mem_wdata),
      .merged (mem_merged_s),
      .ovf    (mem_ovf_s)
   );

   // Merge this cycle's events into the accumulator and decide retirement.
   always_comb begin
      acc_nxt_s   = acc_r;
      state_nxt_s = state_r;
      byte_ovf_s  = 1'b0;
      done_ok_s   = 1'b0;
      proto_err_s = 1'b0;

      if (ev_fetch) begin
         if (acc_r.len < MAX_LEN_C) begin
            acc_nxt_s.insn = insert_byte(acc_r.insn, acc_r.len, ev_fetch_byte);
            acc_nxt_s.len  = acc_r.len + 3'd1;
            acc_nxt_s.pc   = (acc_r.len == 3'd0) ? ev_fetch_pc : acc_r.pc;
         end else begin
            byte_ovf_s = 1'b1;
         end
      end else begin
         byte_ovf_s = 1'b0;
      end

      // Only the first read on each port belongs to the packet.
      if (ev_reg_rd[0] && !acc_r.reg1_rd) begin
         acc_nxt_s.reg1_rd    = 1'b1;
         acc_nxt_s.reg1_rnum  = ev_reg_rnum[3:0];
         acc_nxt_s.reg1_rdata = ev_reg_rdata[15:0];
      end else begin
         acc_nxt_s.reg1_rd = acc_r.reg1_rd;
      end
      if (ev_reg_rd[1] && !acc_r.reg2_rd) begin
         acc_nxt_s.reg2_rd    = 1'b1;
         acc_nxt_s.reg2_rnum  = ev_reg_rnum[7:4];
         acc_nxt_s.reg2_rdata = ev_reg_rdata[31:16];
      end else begin
         acc_nxt_s.reg2_rd = acc_r.reg2_rd;
      end

      case (state_r)
         ST_IDLE: begin
            if (ev_fetch && ev_done) begin
               done_ok_s = 1'b1;
            end else if (ev_fetch) begin
               state_nxt_s = ST_ACTIVE;
            end else if (ev_done) begin
               proto_err_s = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (ev_done) begin
               done_ok_s   = 1'b1;
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_ACTIVE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State, accumulator, registered packet and sticky error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         acc_r     <= '0;
         pkt_r     <= '0;
         mem_pkt_r <= '0;
         valid_r   <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         valid_r <= done_ok_s;
         err_r   <= err_r | proto_err_s | (CHECK_OVF & (byte_ovf_s | mem_ovf_s));
         if (done_ok_s) begin
            acc_r     <= '0;
            pkt_r     <= acc_nxt_s;
            mem_pkt_r <= mem_merged_s;
         end else begin
            acc_r <= acc_nxt_s;
         end
      end
   end

   assign z80fi_valid      = valid_r;
   assign z80fi_insn       = pkt_r.insn;
   assign z80fi_insn_len   = pkt_r.len;
   assign z80fi_pc_rdata   = pkt_r.pc;
   assign z80fi_reg1_rd    = pkt_r.reg1_rd;
   assign z80fi_reg1_rnum  = pkt_r.reg1_rnum;
   assign z80fi_reg1_rdata = pkt_r.reg1_rdata;
   assign z80fi_reg2_rd    = pkt_r.reg2_rd;
   assign z80fi_reg2_rnum  = pkt_r.reg2_rnum;
   assign z80fi_reg2_rdata = pkt_r.reg2_rdata;
   assign z80fi_mem_wr     = mem_pkt_r.wr;
   assign z80fi_mem_waddr  = mem_pkt_r.waddr;
   assign z80fi_mem_wdata  = mem_pkt_r.wdata;
   assign z80fi_mem_wr2    = mem_pkt_r.wr2;
   assign z80fi_mem_waddr2 = mem_pkt_r.waddr2;
   assign z80fi_mem_wdata2 = mem_pkt_r.wdata2;
   assign z80fi_err        = err_r;

endmodule

// File: tb/tb_z80fi_insn_collector.sv
// Directed bench for z80fi_insn_collector: hand-computed packets for LD (nn),BC, NOP,
// back-to-back, byte/write overflow, orphan ev_done and mid-instruction reset.
module tb_z80fi_insn_collector;

   logic        clk = 1'b0;
   logic        reset;
   logic        ev_fetch;
   logic [7:0]  ev_fetch_byte;
   logic [15:0] ev_fetch_pc;
   logic [1:0]  ev_reg_rd;
   logic [7:0]  ev_reg_rnum;
   logic [31:0] ev_reg_rdata;
   logic        ev_mem_wr;
   logic [15:0] ev_mem_waddr;
   logic [7:0]  ev_mem_wdata;
   logic        ev_done;
   logic        z80fi_valid;
   logic [31:0] z80fi_insn;
   logic [2:0]  z80fi_insn_len;
   logic [15:0] z80fi_pc_rdata;
   logic [3:0]  z80fi_reg1_rnum, z80fi_reg2_rnum;
   logic [15:0] z80fi_reg1_rdata, z80fi_reg2_rdata;
   logic        z80fi_reg1_rd, z80fi_reg2_rd;
   logic        z80fi_mem_wr, z80fi_mem_wr2;
   logic [15:0] z80fi_mem_waddr, z80fi_mem_waddr2;
   logic [7:0]  z80fi_mem_wdata, z80fi_mem_wdata2;
   logic        z80fi_err;

   int tests_run = 0;
   int tests_failed = 0;

   z80fi_insn_collector dut (
      .clk              (clk),
      .reset            (reset),
      .ev_fetch         (ev_fetch),
      .ev_fetch_byte    (ev_fetch_byte),
      .ev_fetch_pc      (ev_fetch_pc),
      .ev_reg_rd        (ev_reg_rd),
      .ev_reg_rnum      (ev_reg_rnum),
      .ev_reg_rdata     (ev_reg_rdata),
      .ev_mem_wr        (ev_mem_wr),
      .ev_mem_waddr     (ev_mem_waddr),
      .ev_mem_wdata     (ev_mem_wdata),
      .ev_done          (ev_done),
      .z80fi_valid      (z80fi_valid),
      .z80fi_insn       (z80fi_insn),
      .z80fi_insn_len   (z80fi_insn_len),
      .z80fi_pc_rdata   (z80fi_pc_rdata),
      .z80fi_reg1_rnum  (z80fi_reg1_rnum),
      .z80fi_reg2_rnum  (z80fi_reg2_rnum),
      .z80fi_reg1_rdata (z80fi_reg1_rdata),
      .z80fi_reg2_rdata (z80fi_reg2_rdata),
      .z80fi_reg1_rd    (z80fi_reg1_rd),
      .z80fi_reg2_rd    (z80fi_reg2_rd),
      .z80fi_mem_wr     (z80fi_mem_wr),
      .z80fi_mem_wr2    (z80fi_mem_wr2),
      .z80fi_mem_waddr  (z80fi_mem_waddr),
      .z80fi_mem_waddr2 (z80fi_mem_waddr2),
      .z80fi_mem_wdata  (z80fi_mem_wdata),
      .z80fi_mem_wdata2 (z80fi_mem_wdata2),
      .z80fi_err        (z80fi_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic clear_ev();
      ev_fetch      = 1'b0;
      ev_fetch_byte = 8'h00;
      ev_fetch_pc   = 16'h0000;
      ev_reg_rd     = 2'b00;
      ev_reg_rnum   = 8'h00;
      ev_reg_rdata  = 32'h0;
      ev_mem_wr     = 1'b0;
      ev_mem_waddr  = 16'h0000;
      ev_mem_wdata  = 8'h00;
      ev_done       = 1'b0;
   endtask

   // Advance one clock; inputs were set before the edge and are cleared 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
      clear_ev();
   endtask

   task automatic fetch(input logic [7:0] b, input logic [15:0] pc);
      ev_fetch      = 1'b1;
      ev_fetch_byte = b;
      ev_fetch_pc   = pc;
   endtask

   task automatic mwrite(input logic [15:0] a, input logic [7:0] d);
      ev_mem_wr    = 1'b1;
      ev_mem_waddr = a;
      ev_mem_wdata = d;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      clear_ev();
      reset = 1'b1;
      tick();
      tick();
      check("rst_valid", {31'd0, z80fi_valid}, 32'd0);
      check("rst_insn", z80fi_insn, 32'd0);
      check("rst_len", {29'd0, z80fi_insn_len}, 32'd0);
      check("rst_err", {31'd0, z80fi_err}, 32'd0);
      reset = 1'b0;
      tick();

      // LD (1234h),BC
      fetch(8'hED, 16'h0100);
      ev_reg_rd = 2'b01; ev_reg_rnum = 8'h08; ev_reg_rdata = 32'h0000_BEEF;
      tick();
      check("ld_valid_early", {31'd0, z80fi_valid}, 32'd0);
      fetch(8'h43, 16'h0101);
      ev_reg_rd = 2'b01; ev_reg_rnum = 8'h09; ev_reg_rdata = 32'h0000_1111;
      tick();
      fetch(8'h34, 16'h0102); mwrite(16'h1234, 8'hEF);
      tick();
      check("ld_valid_pre", {31'd0, z80fi_valid}, 32'd0);
      fetch(8'h12, 16'h0103); mwrite(16'h1235, 8'hBE); ev_done = 1'b1;
      tick();
      check("ld_valid", {31'd0, z80fi_valid}, 32'd1);
      check("ld_insn", z80fi_insn, 32'h1234_43ED);
      check("ld_len", {29'd0, z80fi_insn_len}, 32'd4);
      check("ld_pc", {16'd0, z80fi_pc_rdata}, 32'h0100);
      check("ld_reg1", {11'd0, z80fi_reg1_rd, z80fi_reg1_rnum, z80fi_reg1_rdata}, {11'd0, 1'b1, 4'b1000, 16'hBEEF});
      check("ld_reg2_rd", {31'd0, z80fi_reg2_rd}, 32'd0);
      check("ld_wr1", {7'd0, z80fi_mem_wr, z80fi_mem_waddr, z80fi_mem_wdata}, {7'd0, 1'b1, 16'h1234, 8'hEF});
      check("ld_wr2", {7'd0, z80fi_mem_wr2, z80fi_mem_waddr2, z80fi_mem_wdata2}, {7'd0, 1'b1, 16'h1235, 8'hBE});
      check("ld_err", {31'd0, z80fi_err}, 32'd0);
      tick();
      check("ld_valid_drop", {31'd0, z80fi_valid}, 32'd0);
      check("ld_insn_hold", z80fi_insn, 32'h1234_43ED);

      // NOP, then a 2-byte insn fetched during the NOP valid cycle
      fetch(8'h00, 16'h0200); ev_done = 1'b1;
      tick();
      check("nop_valid", {31'd0, z80fi_valid}, 32'd1);
      check("nop_insn", z80fi_insn, 32'd0);
      check("nop_len", {29'd0, z80fi_insn_len}, 32'd1);
      check("nop_pc", {16'd0, z80fi_pc_rdata}, 32'h0200);
      check("nop_wr", {30'd0, z80fi_mem_wr, z80fi_reg1_rd}, 32'd0);
      fetch(8'h3E, 16'h0201);
      ev_reg_rd = 2'b10; ev_reg_rnum = 8'h30; ev_reg_rdata = 32'h1234_0000;
      tick();
      check("b2b_valid_low", {31'd0, z80fi_valid}, 32'd0);
      check("b2b_first_len", {29'd0, z80fi_insn_len}, 32'd1);
      check("b2b_first_insn", z80fi_insn, 32'd0);
      fetch(8'h05, 16'h0202); ev_done = 1'b1;
      tick();
      check("b2b_valid", {31'd0, z80fi_valid}, 32'd1);
      check("b2b_insn", z80fi_insn, 32'h0000_053E);
      check("b2b_len", {29'd0, z80fi_insn_len}, 32'd2);
      check("b2b_pc", {16'd0, z80fi_pc_rdata}, 32'h0201);
      check("b2b_reg2", {11'd0, z80fi_reg2_rd, z80fi_reg2_rnum, z80fi_reg2_rdata}, {11'd0, 1'b1, 4'h3, 16'h1234});
      check("b2b_reg1_rd", {31'd0, z80fi_reg1_rd}, 32'd0);
      check("b2b_err", {31'd0, z80fi_err}, 32'd0);
      tick();

      // Five opcode bytes: fifth is overflow
      for (int i = 0; i < 5; i++) begin
         fetch(8'(i + 1), 16'(16'h0300 + i));
         if (i == 4) ev_done = 1'b1;
         tick();
      end
      check("ovf_valid", {31'd0, z80fi_valid}, 32'd1);
      check("ovf_insn", z80fi_insn, 32'h0403_0201);
      check("ovf_len", {29'd0, z80fi_insn_len}, 32'd4);
      check("ovf_pc", {16'd0, z80fi_pc_rdata}, 32'h0300);
      check("ovf_err", {31'd0, z80fi_err}, 32'd1);
      tick();

      // Reset in the middle of a 2-byte-so-far instruction
      fetch(8'hAA, 16'h0400);
      tick();
      fetch(8'hBB, 16'h0401);
      tick();
      reset = 1'b1;
      #1;
      check("mrst_insn", z80fi_insn, 32'd0);
      check("mrst_len", {29'd0, z80fi_insn_len}, 32'd0);
      check("mrst_err", {31'd0, z80fi_err}, 32'd0);
      tick();
      reset = 1'b0;
      tick();
      fetch(8'hC9, 16'h0500); ev_done = 1'b1;
      tick();
      check("post_rst_valid", {31'd0, z80fi_valid}, 32'd1);
      check("post_rst_insn", z80fi_insn, 32'h0000_00C9);
      check("post_rst_len", {29'd0, z80fi_insn_len}, 32'd1);
      check("post_rst_pc", {16'd0, z80fi_pc_rdata}, 32'h0500);
      tick();

      // Three memory writes: third dropped
      fetch(8'h77, 16'h0600); mwrite(16'h4000, 8'h11);
      tick();
      check("mov_err_pre", {31'd0, z80fi_err}, 32'd0);
      mwrite(16'h4001, 8'h22);
      tick();
      mwrite(16'h4002, 8'h33); ev_done = 1'b1;
      tick();
      check("mov_valid", {31'd0, z80fi_valid}, 32'd1);
      check("mov_wr1", {7'd0, z80fi_mem_wr, z80fi_mem_waddr, z80fi_mem_wdata}, {7'd0, 1'b1, 16'h4000, 8'h11});
      check("mov_wr2", {7'd0, z80fi_mem_wr2, z80fi_mem_waddr2, z80fi_mem_wdata2}, {7'd0, 1'b1, 16'h4001, 8'h22});
      check("mov_err", {31'd0, z80fi_err}, 32'd1);
      tick();

      // ev_done with no instruction byte
      do_reset();
      tick();
      check("orph_err_pre", {31'd0, z80fi_err}, 32'd0);
      ev_done = 1'b1;
      tick();
      check("orph_valid", {31'd0, z80fi_valid}, 32'd0);
      check("orph_err", {31'd0, z80fi_err}, 32'd1);
      tick();
      check("orph_valid2", {31'd0, z80fi_valid}, 32'd0);
      check("orph_err_sticky", {31'd0, z80fi_err}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
